// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: width, opcodes, flag masks, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 16;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_LSL  = 4'd9;
    localparam logic [3:0] OP_LSR  = 4'd10;
    localparam logic [3:0] OP_ASR  = 4'd11;

    // Flag-write masks for the downstream flag register
    localparam logic [2:0] WRF_NONE = 3'b000;
    localparam logic [2:0] WRF_Z    = 3'b001;
    localparam logic [2:0] WRF_SZ   = 3'b010;
    localparam logic [2:0] WRF_SCZ  = 3'b011;
    localparam logic [2:0] WRF_OSCZ = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic o;
        logic s;
        logic c;
        logic z;
    } flags_t;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              c;
    } shift_res_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
    endfunction

    // One-bit shift step; c is the bit that falls off the end.
    function automatic shift_res_t shift_step(input logic [DATA_W-1:0] v, input logic [3:0] op);
        shift_res_t r;
        r.val = v;
        r.c   = 1'b0;
        case (op)
            OP_LSL: begin
                r.val = {v[DATA_W-2:0], 1'b0};
                r.c   = v[DATA_W-1];
            end
            OP_LSR: begin
                r.val = {1'b0, v[DATA_W-1:1]};
                r.c   = v[0];
            end
            OP_ASR: begin
                r.val = {v[DATA_W-1], v[DATA_W-1:1]};
                r.c   = v[0];
            end
            default: begin
                r.val = v;
                r.c   = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between a requester and the sequential ALU.
// Latency: n/a (wiring only).
// Backpressure: none; requester watches busy, start is dropped unless the ALU is idle.
interface alu_seq_if;
    import alu_pkg::*;

    logic              start;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              out_O;
    logic              out_S;
    logic              out_C;
    logic              out_Z;
    logic [2:0]        W_RF;

    modport master (
        output start, op, a, b,
        input  busy, done, result, out_O, out_S, out_C, out_Z, W_RF
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, out_O, out_S, out_C, out_Z, W_RF
    );

endinterface

// File: rtl/alu_addsub.sv
// Adder with carry-in shared by ADD/SUB/INC/DEC; subtraction is fed as x + ~y + 1.
// Latency: combinational.
// Backpressure: none.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o,
    output logic              ovf_o
);

    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, x_i} + {1'b0, y_i} + {{DATA_W{1'b0}}, cin_i};
    assign sum_o    = full_sum[DATA_W-1:0];
    assign cout_o   = full_sum[DATA_W];
    // Overflow: both addends share a sign and the sum's sign differs from it.
    assign ovf_o    = (x_i[DATA_W-1] == y_i[DATA_W-1]) && (sum_o[DATA_W-1] != x_i[DATA_W-1]);

endmodule

// File: rtl/alu_seq.sv
// Sequential 16-bit ALU: single-cycle arithmetic/logic, bit-serial shifts (one bit per cycle).
// Latency: done one cycle after start, or 1+n cycles for a shift by n>0.
// Backpressure: start is sampled only in IDLE; starts while busy are dropped, not queued.
module alu_seq
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        shop_q, shop_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] result_q, result_d;
    flags_t            flg_q, flg_d;
    logic [2:0]        wrf_q, wrf_d;

    logic [DATA_W-1:0] as_y;
    logic              as_cin;
    logic [DATA_W-1:0] as_sum;
    logic              as_cout;
    logic              as_ovf;

    logic [DATA_W-1:0] alu_res;
    flags_t            alu_flg;
    logic [2:0]        alu_wrf;

    logic              shift_nz;
    shift_res_t        step;

    // A shift by zero finishes in one cycle through the single-cycle path.
    assign shift_nz = is_shift_op(bus.op) && (bus.b[3:0] != 4'd0);
    assign step     = shift_step(sh_q, shop_q);

    // Adder operand select: SUB/DEC become x + ~y + 1.
    always_comb begin
        as_y   = bus.b;
        as_cin = 1'b0;
        case (bus.op)
            OP_SUB: begin
                as_y   = ~bus.b;
                as_cin = 1'b1;
            end
            OP_INC: as_y = ONE;
            OP_DEC: begin
                as_y   = ~ONE;
                as_cin = 1'b1;
            end
            default: begin
                as_y   = bus.b;
                as_cin = 1'b0;
            end
        endcase
    end

    alu_addsub u_addsub (
        .x_i    (bus.a),
        .y_i    (as_y),
        .cin_i  (as_cin),
        .sum_o  (as_sum),
        .cout_o (as_cout),
        .ovf_o  (as_ovf)
    );

    // Single-cycle result, flags and write mask; flags outside the mask stay 0.
    always_comb begin
        alu_res = '0;
        alu_flg = '0;
        alu_wrf = WRF_NONE;
        case (bus.op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                alu_res   = as_sum;
                alu_flg.o = as_ovf;
                alu_flg.c = as_cout;
                alu_wrf   = WRF_OSCZ;
            end
            OP_AND: begin
                alu_res = bus.a & bus.b;
                alu_wrf = WRF_SZ;
            end
            OP_OR: begin
                alu_res = bus.a | bus.b;
                alu_wrf = WRF_SZ;
            end
            OP_XOR: begin
                alu_res = bus.a ^ bus.b;
                alu_wrf = WRF_SZ;
            end
            OP_NOT: begin
                alu_res = ~bus.a;
                alu_wrf = WRF_SZ;
            end
            OP_PASS: begin
                alu_res = bus.a;
                alu_wrf = WRF_Z;
            end
            OP_LSL, OP_LSR, OP_ASR: begin
                // Only reached with a zero shift count: nothing shifted out.
                alu_res = bus.a;
                alu_wrf = WRF_SCZ;
            end
            default: begin
                alu_res = '0;
                alu_wrf = WRF_NONE;
            end
        endcase
        if ((alu_wrf == WRF_SZ) || (alu_wrf == WRF_SCZ) || (alu_wrf == WRF_OSCZ)) begin
            alu_flg.s = alu_res[DATA_W-1];
        end
        if (alu_wrf != WRF_NONE) begin
            alu_flg.z = (alu_res == '0);
        end
    end

    // Next-state logic: IDLE -> (SHIFT ->) DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = shift_nz ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: capture in IDLE, shift in SHIFT, publish when entering DONE.
    always_comb begin
        cnt_d    = cnt_q;
        shop_d   = shop_q;
        sh_d     = sh_q;
        result_d = result_q;
        flg_d    = flg_q;
        wrf_d    = wrf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (shift_nz) begin
                        sh_d   = bus.a;
                        cnt_d  = bus.b[3:0];
                        shop_d = bus.op;
                        wrf_d  = WRF_SCZ;
                    end else begin
                        result_d = alu_res;
                        flg_d    = alu_flg;
                        wrf_d    = alu_wrf;
                        cnt_d    = 4'd0;
                    end
                end
            end
            ST_SHIFT: begin
                sh_d  = step.val;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = step.val;
                    flg_d.o  = 1'b0;
                    flg_d.s  = step.val[DATA_W-1];
                    flg_d.c  = step.c;
                    flg_d.z  = (step.val == '0);
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset clears everything, even mid-shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            shop_q   <= OP_ADD;
            sh_q     <= '0;
            result_q <= '0;
            flg_q    <= '0;
            wrf_q    <= WRF_NONE;
        end else begin
            cnt_q    <= cnt_d;
            shop_q   <= shop_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            flg_q    <= flg_d;
            wrf_q    <= wrf_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.out_O  = flg_q.o;
    assign bus.out_S  = flg_q.s;
    assign bus.out_C  = flg_q.c;
    assign bus.out_Z  = flg_q.z;
    // The mask is only presented during the done cycle.
    assign bus.W_RF   = (state_q == ST_DONE) ? wrf_q : WRF_NONE;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomised checks of alu_seq through a scoreboard of expected results.
// Latency: each operation's done cycle is checked against the expected 1 or 1+n.
// Backpressure: exercises starts ignored while busy and starts coinciding with reset.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic        o;
        logic        s;
        logic        c;
        logic        z;
        logic [2:0]  wrf;
        logic [5:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    alu_seq_if bus ();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] res, input logic o, input logic s,
                                input logic c, input logic z, input logic [2:0] wrf,
                                input logic [5:0] lat);
        exp_t e;
        e.res = res; e.o = o; e.s = s; e.c = c; e.z = z; e.wrf = wrf; e.lat = lat;
        return e;
    endfunction

    // Reference model built from integer arithmetic and bit loops.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] w;
        int          sr;
        logic [15:0] v;
        int          n;
        e     = '0;
        e.lat = 6'd1;
        w     = '0;
        sr    = 0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                case (op)
                    4'd0: begin
                        w  = {1'b0, a} + {1'b0, b};
                        sr = int'($signed(a)) + int'($signed(b));
                    end
                    4'd1: begin
                        w  = {1'b0, a} + {1'b0, ~b} + 17'd1;
                        sr = int'($signed(a)) - int'($signed(b));
                    end
                    4'd2: begin
                        w  = {1'b0, a} + 17'd1;
                        sr = int'($signed(a)) + 1;
                    end
                    default: begin
                        w  = {1'b0, a} + 17'h0FFFF;
                        sr = int'($signed(a)) - 1;
                    end
                endcase
                e.res = w[15:0];
                e.c   = w[16];
                e.o   = (sr > 32767) || (sr < -32768);
                e.wrf = 3'b100;
            end
            4'd4: begin e.res = a & b; e.wrf = 3'b010; end
            4'd5: begin e.res = a | b; e.wrf = 3'b010; end
            4'd6: begin e.res = a ^ b; e.wrf = 3'b010; end
            4'd7: begin e.res = ~a;    e.wrf = 3'b010; end
            4'd8: begin e.res = a;     e.wrf = 3'b001; end
            4'd9, 4'd10, 4'd11: begin
                n = int'(b[3:0]);
                v = a;
                for (int k = 0; k < n; k++) begin
                    if (op == 4'd9) begin
                        e.c = v[15];
                        v   = v << 1;
                    end else if (op == 4'd10) begin
                        e.c = v[0];
                        v   = v >> 1;
                    end else begin
                        e.c = v[0];
                        v   = {v[15], v[15:1]};
                    end
                end
                e.res = v;
                e.wrf = 3'b011;
                e.lat = (n == 0) ? 6'd1 : 6'(n + 1);
            end
            default: e.wrf = 3'b000;
        endcase
        if (e.wrf != 3'b000)                      e.z = (e.res == 16'h0000);
        if (e.wrf != 3'b000 && e.wrf != 3'b001)   e.s = e.res[15];
        return e;
    endfunction

    // Issue one operation and follow it to its done cycle; returns at the done-cycle negedge.
    task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input exp_t e, input bit poke_mid);
        int   cyc;
        exp_t want;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        sb_q.push_back(e);
        @(negedge clk);
        // Scramble operands after capture; they must no longer matter.
        bus.start = 1'b0; bus.a = ~a; bus.b = 16'($urandom); bus.op = 4'($urandom);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            chk($sformatf("%s busy c%0d", name, cyc), bus.busy, 1);
            chk($sformatf("%s wrf c%0d", name, cyc), bus.W_RF, 0);
            if (poke_mid && cyc == 2) begin
                bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h0001; bus.b = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        want = sb_q.pop_front();
        chk({name, " latency"}, cyc, want.lat);
        chk({name, " done busy"}, bus.busy, 1);
        chk({name, " result"}, bus.result, want.res);
        chk({name, " O"}, bus.out_O, want.o);
        chk({name, " S"}, bus.out_S, want.s);
        chk({name, " C"}, bus.out_C, want.c);
        chk({name, " Z"}, bus.out_Z, want.z);
        chk({name, " W_RF"}, bus.W_RF, want.wrf);
    endtask

    task automatic idle_chk(input string name, input exp_t e);
        @(negedge clk);
        chk({name, " post busy"}, bus.busy, 0);
        chk({name, " post done"}, bus.done, 0);
        chk({name, " post W_RF"}, bus.W_RF, 0);
        chk({name, " held result"}, bus.result, e.res);
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input exp_t e, input bit poke_mid);
        run_op(name, op, a, b, e, poke_mid);
        idle_chk(name, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        bit          seen_done;

        rst = 1'b1; bus.start = 1'b0; bus.op = 4'd0; bus.a = 16'h0000; bus.b = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst result", bus.result, 16'h0000);
        chk("rst flags", {bus.out_O, bus.out_S, bus.out_C, bus.out_Z}, 4'b0000);
        chk("rst W_RF", bus.W_RF, 3'b000);
        rst = 1'b0;

        do_op("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, mk(16'h8000, 1, 1, 0, 0, 3'b100, 1), 0);
        do_op("sub_zero", OP_SUB,  16'h0005, 16'h0005, mk(16'h0000, 0, 0, 1, 1, 3'b100, 1), 0);
        do_op("lsl4",     OP_LSL,  16'h1001, 16'h0004, mk(16'h0010, 0, 0, 1, 0, 3'b011, 5), 0);
        do_op("asr15",    OP_ASR,  16'h8000, 16'h000F, mk(16'hFFFF, 0, 1, 0, 0, 3'b011, 16), 1);
        do_op("inc_wrap", OP_INC,  16'hFFFF, 16'h1234, mk(16'h0000, 0, 0, 1, 1, 3'b100, 1), 0);
        do_op("dec_ovf",  OP_DEC,  16'h8000, 16'h0000, mk(16'h7FFF, 1, 0, 1, 0, 3'b100, 1), 0);
        do_op("sub_brw",  OP_SUB,  16'h0000, 16'h0001, mk(16'hFFFF, 0, 1, 0, 0, 3'b100, 1), 0);
        do_op("or",       OP_OR,   16'h1234, 16'h8001, mk(16'h9235, 0, 1, 0, 0, 3'b010, 1), 0);
        do_op("xor_zero", OP_XOR,  16'hFFFF, 16'hFFFF, mk(16'h0000, 0, 0, 0, 1, 3'b010, 1), 0);
        do_op("pass_neg", OP_PASS, 16'h8000, 16'hFFFF, mk(16'h8000, 0, 0, 0, 0, 3'b001, 1), 0);
        do_op("pass_zero",OP_PASS, 16'h0000, 16'hFFFF, mk(16'h0000, 0, 0, 0, 1, 3'b001, 1), 0);
        do_op("lsr_n0",   OP_LSR,  16'hABCD, 16'h0010, mk(16'hABCD, 0, 1, 0, 0, 3'b011, 1), 0);
        do_op("lsr2",     OP_LSR,  16'h0003, 16'h0002, mk(16'h0000, 0, 0, 1, 1, 3'b011, 3), 0);
        do_op("rsv12",    4'd12,   16'hFFFF, 16'hFFFF, mk(16'h0000, 0, 0, 0, 0, 3'b000, 1), 0);
        do_op("rsv15",    4'd15,   16'h0000, 16'h0000, mk(16'h0000, 0, 0, 0, 0, 3'b000, 1), 0);
        do_op("asr1",     OP_ASR,  16'h4000, 16'h0001, mk(16'h2000, 0, 0, 0, 0, 3'b011, 2), 0);

        // AND to zero, then a start during the DONE cycle must be dropped.
        e = mk(16'h0000, 0, 0, 0, 1, 3'b010, 1);
        run_op("and_zero", OP_AND, 16'h0F0F, 16'hF0F0, e, 0);
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h0001; bus.b = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done busy", bus.busy, 0);
        chk("start_in_done done", bus.done, 0);
        @(negedge clk);
        chk("start_in_done later done", bus.done, 0);
        chk("start_in_done result", bus.result, 16'h0000);

        // Leave a nonzero result so the reset clearing is visible.
        do_op("not", OP_NOT, 16'h00FF, 16'h0000, mk(16'hFF00, 0, 1, 0, 0, 3'b010, 1), 0);

        // Reset mid-shift, with a start coinciding with reset.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_LSR; bus.a = 16'hFFFF; bus.b = 16'h0008;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rst_mid busy t1", bus.busy, 1);
        @(negedge clk);
        chk("rst_mid busy t2", bus.busy, 1);
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h0001; bus.b = 16'h0001;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_mid busy", bus.busy, 0);
        chk("rst_mid done", bus.done, 0);
        chk("rst_mid result", bus.result, 16'h0000);
        chk("rst_mid flags", {bus.out_O, bus.out_S, bus.out_C, bus.out_Z}, 4'b0000);
        chk("rst_mid W_RF", bus.W_RF, 3'b000);
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        chk("rst_mid no done", seen_done, 0);
        do_op("add_after_rst", OP_ADD, 16'h1234, 16'h1111, mk(16'h2345, 0, 0, 0, 0, 3'b100, 1), 0);

        // Randomised operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            e   = model(rop, ra, rb);
            do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, e, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
